// File: rtl/m2_pkg.sv
// Shared types and constants for the milestone-2 IDCT block scheduler.
package m2_pkg;

    localparam int Y_BLOCKS         = 1200;
    localparam int UV_BLOCKS        = 600;
    localparam int TOTAL_BLOCKS_DEF = Y_BLOCKS + 2 * UV_BLOCKS;

    typedef enum logic [2:0] {
        S_M2_IDLE,
        S_M2_LI_FS,
        S_M2_LI_CT,
        S_M2_CS_FS,
        S_M2_CT_WS,
        S_M2_LO_WS,
        S_M2_DONE
    } m2_state_type;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FS,
        GNT_WS
    } m2_grant_type;

    // FS owns the port while it is fetching, WS while it is writing back.
    function automatic m2_grant_type grant_of(input m2_state_type s);
        case (s)
            S_M2_LI_FS, S_M2_CS_FS: grant_of = GNT_FS;
            S_M2_CT_WS, S_M2_LO_WS: grant_of = GNT_WS;
            default:                grant_of = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/m2_sram_arbiter.sv
// Combinational 2:1 mux of the single SRAM port between the fetch (read-only)
// and write-back units.
module m2_sram_arbiter
    import m2_pkg::*;
(
    input  m2_grant_type grant_i,
    input  logic [17:0]  fs_address_i,
    input  logic [17:0]  ws_address_i,
    input  logic         ws_we_n_i,
    input  logic [15:0]  ws_write_data_i,
    output logic [17:0]  sram_address_o,
    output logic         sram_we_n_o,
    output logic [15:0]  sram_write_data_o
);

    always_comb begin
        sram_address_o    = 18'd0;
        sram_we_n_o       = 1'b1;
        sram_write_data_o = 16'd0;
        case (grant_i)
            GNT_FS: begin
                sram_address_o = fs_address_i;
            end
            GNT_WS: begin
                sram_address_o    = ws_address_i;
                sram_we_n_o       = ws_we_n_i;
                sram_write_data_o = ws_write_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m2_block_scheduler.sv
// Sequencer for the IDCT stage: overlaps {CS(k) || FS(k+1)} and {CT(k+1) || WS(k)}
// and hands the SRAM port to whichever of FS/WS is active.
module m2_block_scheduler
    import m2_pkg::*;
#(
    parameter int TOTAL_BLOCKS = TOTAL_BLOCKS_DEF,
    parameter int BLK_W        = 12
) (
    input  logic             CLOCK_50_I,
    input  logic             Resetn,
    input  logic             M2_start,
    output logic             M2_done,
    output logic             FS_start,
    output logic             CT_start,
    output logic             CS_start,
    output logic             WS_start,
    input  logic             FS_done,
    input  logic             CT_done,
    input  logic             CS_done,
    input  logic             WS_done,
    input  logic [17:0]      FS_SRAM_address,
    input  logic [17:0]      WS_SRAM_address,
    input  logic             WS_SRAM_we_n,
    input  logic [15:0]      WS_SRAM_write_data,
    output logic [17:0]      SRAM_address,
    output logic             SRAM_we_n,
    output logic [15:0]      SRAM_write_data,
    output logic [BLK_W-1:0] block_idx,
    output m2_state_type     M2_state
);

    // Unit vectors are ordered {WS, CS, CT, FS}. A unit is started by a one-cycle
    // start pulse and answers with a one-cycle done pulse; a phase ends once every
    // unit it started has answered, and the next phase starts one cycle later.
    m2_state_type     state_q, state_d;
    logic [BLK_W-1:0] block_idx_q, block_idx_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0]       start_q, start_d;
    logic             done_q, done_d;

    logic [3:0] exp_v;
    logic [3:0] done_v;
    logic       all_done;
    logic       last_blk;
    logic       next_last_blk;

    assign done_v        = {WS_done, CS_done, CT_done, FS_done};
    assign last_blk      = (block_idx_q == BLK_W'(TOTAL_BLOCKS - 1));
    assign next_last_blk = (block_idx_q == BLK_W'(TOTAL_BLOCKS - 2));
    assign all_done      = &(seen_q | done_v | ~exp_v);

    always_comb begin
        exp_v = 4'b0000;
        case (state_q)
            S_M2_LI_FS: exp_v = 4'b0001;
            S_M2_LI_CT: exp_v = 4'b0010;
            S_M2_CS_FS: exp_v = {2'b01, 1'b0, ~last_blk};
            S_M2_CT_WS: exp_v = 4'b1010;
            S_M2_LO_WS: exp_v = 4'b1000;
            default:    exp_v = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        block_idx_d = block_idx_q;
        seen_d      = seen_q | (done_v & exp_v);
        start_d     = 4'b0000;
        done_d      = 1'b0;
        case (state_q)
            S_M2_IDLE: begin
                block_idx_d = '0;
                if (M2_start) begin
                    state_d = S_M2_LI_FS;
                    start_d = 4'b0001;
                end
            end
            S_M2_LI_FS: begin
                if (all_done) begin
                    state_d = S_M2_LI_CT;
                    start_d = 4'b0010;
                end
            end
            S_M2_LI_CT: begin
                if (all_done) begin
                    state_d = S_M2_CS_FS;
                    start_d = {2'b01, 1'b0, ~last_blk};
                end
            end
            S_M2_CS_FS: begin
                if (all_done) begin
                    if (last_blk) begin
                        state_d = S_M2_LO_WS;
                        start_d = 4'b1000;
                    end else begin
                        state_d = S_M2_CT_WS;
                        start_d = 4'b1010;
                    end
                end
            end
            S_M2_CT_WS: begin
                if (all_done) begin
                    state_d     = S_M2_CS_FS;
                    block_idx_d = block_idx_q + BLK_W'(1);
                    start_d     = {2'b01, 1'b0, ~next_last_blk};
                end
            end
            S_M2_LO_WS: begin
                if (all_done) begin
                    state_d = S_M2_DONE;
                    done_d  = 1'b1;
                end
            end
            S_M2_DONE: begin
                state_d = S_M2_IDLE;
            end
            default: begin
                state_d = S_M2_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            seen_d = 4'b0000;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state_q     <= S_M2_IDLE;
            block_idx_q <= '0;
            seen_q      <= 4'b0000;
            start_q     <= 4'b0000;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_idx_q <= block_idx_d;
            seen_q      <= seen_d;
            start_q     <= start_d;
            done_q      <= done_d;
        end
    end

    assign FS_start  = start_q[0];
    assign CT_start  = start_q[1];
    assign CS_start  = start_q[2];
    assign WS_start  = start_q[3];
    assign M2_done   = done_q;
    assign block_idx = block_idx_q;
    assign M2_state  = state_q;

    m2_sram_arbiter u_arb (
        .grant_i           (grant_of(state_q)),
        .fs_address_i      (FS_SRAM_address),
        .ws_address_i      (WS_SRAM_address),
        .ws_we_n_i         (WS_SRAM_we_n),
        .ws_write_data_i   (WS_SRAM_write_data),
        .sram_address_o    (SRAM_address),
        .sram_we_n_o       (SRAM_we_n),
        .sram_write_data_o (SRAM_write_data)
    );

endmodule
